// File: rtl/led_pixel_source.sv
// led_pixel_source
//
// Pixel stream generator for a 1/32-scan dual-half RGB LED panel. It emits
// one upper/lower pixel pair per beat to the column shifter over a
// valid/ready handshake. Each beat is tagged with its column, row address
// and end-of-row/end-of-frame markers. Frames are separated by a fixed idle
// gap. The pixel content comes from a built-in test pattern chosen at frame
// start.
//
// Optional build macro: PATTERN_ANIM_EN
//   defined   -> the pattern column is offset by frame_cnt, so the image
//                scrolls by one column per frame (pix_col still reports the
//                true column)
//   undefined -> static image
//
// Parameters:
//   COLS        pixels per row (power of two, >= 8)
//   ADDR_W      row-address width; rows per half = 2**ADDR_W
//   GAP_CYCLES  idle cycles between frames (>= 1)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         run enable, sampled in IDLE and at the end of the gap
//   pattern    pattern select, latched at frame start
//              (0 alternating, 1 checkerboard, 2 colour bars, 3 solid white)
//   pix_valid  beat available
//   pix_ready  shifter accepts beat
//   pix_data   {b1,g1,r1,b0,g0,r0}; the low three bits are the upper half
//   pix_col    column of the current beat
//   pix_row    row address of the current beat
//   pix_eol    last column of a row
//   pix_eof    last column of the last row
//   frame_cnt  completed frames, wraps 255 -> 0
//   busy       high whenever the block is not idle

module led_pixel_source #(
    parameter int COLS       = 64,
    parameter int ADDR_W     = 5,
    parameter int GAP_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [1:0]               pattern,
    output logic                     pix_valid,
    input  logic                     pix_ready,
    output logic [5:0]               pix_data,
    output logic [$clog2(COLS)-1:0]  pix_col,
    output logic [ADDR_W-1:0]        pix_row,
    output logic                     pix_eol,
    output logic                     pix_eof,
    output logic [7:0]               frame_cnt,
    output logic                     busy
);

    localparam int COL_W = $clog2(COLS);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST = '1;
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [COL_W-1:0]  col_reg, col_next;
    logic [ADDR_W-1:0] row_reg, row_next;
    logic [1:0]        pat_reg, pat_next;
    logic [GAP_W-1:0]  gap_reg, gap_next;
    logic [7:0]        fc_reg, fc_next;
    logic [5:0]        data_reg, data_next;

    logic [COL_W-1:0]  col_eff;
    logic [2:0]        bar;

    // ------------------------------------------------------------------
    // Next-state logic. In RUN pix_valid is always 1, so a transfer is
    // simply pix_ready.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        row_next   = row_reg;
        pat_next   = pat_reg;
        gap_next   = gap_reg;
        fc_next    = fc_reg;

        case (state_reg)
            IDLE: begin
                if (en) begin
                    state_next = RUN;
                    pat_next   = pattern;
                    col_next   = '0;
                    row_next   = '0;
                end
            end
            RUN: begin
                if (pix_ready) begin
                    if (col_reg == COL_LAST) begin
                        col_next = '0;
                        if (row_reg == ROW_LAST) begin
                            row_next   = '0;
                            fc_next    = fc_reg + 8'd1;
                            gap_next   = '0;
                            state_next = GAP;
                        end else begin
                            row_next = row_reg + 1'b1;
                        end
                    end else begin
                        col_next = col_reg + 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_reg == GAP_LAST) begin
                    if (en) begin
                        state_next = RUN;
                        pat_next   = pattern;
                        col_next   = '0;
                        row_next   = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    gap_next = gap_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pixel generation from the *next* column/row, so the registered
    // pix_data lines up with the registered pix_col/pix_row. During a
    // stall none of the inputs to this logic change, so pix_data holds.
    // ------------------------------------------------------------------
`ifdef PATTERN_ANIM_EN
    assign col_eff = COL_W'({{COL_W{1'b0}}, fc_next} + {8'b0, col_next});
`else
    assign col_eff = col_next;
`endif

    // Colour bar index is the top three bits of the column.
    assign bar = 3'(col_eff >> (COL_W - 3));

    always_comb begin
        data_next = 6'b000000;
        if (state_next == RUN) begin
            case (pat_next)
                2'd0: data_next = {2'b00, ~col_eff[0], 2'b00, ~col_eff[0]};
                // Both halves share the row parity, so they are inverses.
                2'd1: data_next = (col_eff[0] ^ row_next[0]) ? 6'b111000
                                                             : 6'b000111;
                2'd2: data_next = {bar, bar};
                default: data_next = 6'b111111;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            col_reg   <= '0;
            row_reg   <= '0;
            pat_reg   <= 2'd0;
            gap_reg   <= '0;
            fc_reg    <= 8'd0;
            data_reg  <= 6'd0;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            row_reg   <= row_next;
            pat_reg   <= pat_next;
            gap_reg   <= gap_next;
            fc_reg    <= fc_next;
            data_reg  <= data_next;
        end
    end

    assign pix_valid = (state_reg == RUN);
    assign pix_data  = data_reg;
    assign pix_col   = col_reg;
    assign pix_row   = row_reg;
    assign pix_eol   = (col_reg == COL_LAST);
    assign pix_eof   = (col_reg == COL_LAST) && (row_reg == ROW_LAST);
    assign frame_cnt = fc_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_led_pixel_source.sv
module tb_led_pixel_source;

    localparam int COLS        = 64;
    localparam int ADDR_W      = 5;
    localparam int GAP         = 16;
    localparam int COL_W       = $clog2(COLS);
    localparam int FRAME_BEATS = COLS * (1 << ADDR_W);

    // Main instance signals
    logic              clk;
    logic              rst_n;
    logic              en;
    logic [1:0]        pattern;
    logic              pix_valid;
    logic              pix_ready;
    logic [5:0]        pix_data;
    logic [COL_W-1:0]  pix_col;
    logic [ADDR_W-1:0] pix_row;
    logic              pix_eol;
    logic              pix_eof;
    logic [7:0]        frame_cnt;
    logic              busy;

    // Small instance (8 columns, 2 rows per half, 1 gap cycle) used to
    // reach the frame counter wrap in a short run.
    logic              s_en;
    logic              s_valid;
    logic [5:0]        s_data;
    logic [2:0]        s_col;
    logic [0:0]        s_row;
    logic              s_eol;
    logic              s_eof;
    logic [7:0]        s_frame_cnt;
    logic              s_busy;

    int vectors     = 0;
    int miscompares = 0;
    int fc_model    = 0;
    int frame_no    = 0;
    int chg_beat    = -1;
    logic [1:0] chg_pat = 2'd0;
    int en_off_beat = -1;

    led_pixel_source #(
        .COLS(COLS), .ADDR_W(ADDR_W), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pattern(pattern),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_col(pix_col), .pix_row(pix_row), .pix_eol(pix_eol),
        .pix_eof(pix_eof), .frame_cnt(frame_cnt), .busy(busy)
    );

    led_pixel_source #(
        .COLS(8), .ADDR_W(1), .GAP_CYCLES(1)
    ) dut_small (
        .clk(clk), .rst_n(rst_n), .en(s_en), .pattern(2'd3),
        .pix_valid(s_valid), .pix_ready(1'b1), .pix_data(s_data),
        .pix_col(s_col), .pix_row(s_row), .pix_eol(s_eol),
        .pix_eof(s_eof), .frame_cnt(s_frame_cnt), .busy(s_busy)
    );

    always #5 clk = ~clk;

    // Reference pixel from the pattern rules, for pattern column cc
    // (already scrolled when animation is enabled) and row r.
    function automatic logic [5:0] model_pixel(input logic [1:0] pat,
                                               input int cc, input int r);
        int bar;
        logic [2:0] b;
        case (pat)
            2'd0: return (cc % 2 == 0) ? 6'b001001 : 6'b000000;
            2'd1: return ((cc + r) % 2 == 0) ? 6'b000111 : 6'b111000;
            2'd2: begin
                bar = cc / (COLS / 8);
                b   = bar[2:0];
                return {b, b};
            end
            default: return 6'b111111;
        endcase
    endfunction

    // Walks one frame from the current negedge (beat k visible), comparing
    // every cycle's outputs with the expected beat. Returns at the negedge
    // after the last transfer, or once stop_beat is the visible beat.
    task automatic run_frame(input logic [1:0] pat, input int ready_pct,
                             input int stop_beat);
        int k;
        int cyc;
        int c;
        int r;
        int shift;
        logic [19:0] exp_t;
        logic [19:0] obs_t;
        k   = 0;
        cyc = 0;
`ifdef PATTERN_ANIM_EN
        shift = fc_model;
`else
        shift = 0;
`endif
        while (k < FRAME_BEATS && k != stop_beat) begin
            if (cyc >= FRAME_BEATS * 20) begin
                vectors++;
                miscompares++;
                $display("FAIL frame_timeout beats=%0d required=%0d", k, FRAME_BEATS);
                break;
            end
            c = k % COLS;
            r = k / COLS;
            exp_t = {1'b1, model_pixel(pat, (c + shift) % COLS, r), 6'(c),
                     5'(r), (c == COLS - 1), (k == FRAME_BEATS - 1)};
            obs_t = {pix_valid, pix_data, pix_col, pix_row, pix_eol, pix_eof};
            vectors++;
            if (obs_t !== exp_t) begin
                miscompares++;
                $display("FAIL beat k=%0d pat=%0d {valid,data,col,row,eol,eof} actual=%05h required=%05h",
                         k, pat, obs_t, exp_t);
            end
            if (k == chg_beat)    pattern = chg_pat;
            if (k == en_off_beat) en = 1'b0;
            pix_ready = ($urandom_range(99) < ready_pct);
            @(posedge clk);
            if (pix_ready) k++;
            @(negedge clk);
            cyc++;
        end
        $display("frame %0d pattern %0d: %0d beats in %0d cycles", frame_no, pat, k, cyc);
        frame_no++;
    endtask

    // Called at the negedge right after the end-of-frame transfer.
    task automatic end_frame();
        fc_model = (fc_model + 1) % 256;
        vectors++;
        if (frame_cnt !== fc_model[7:0]) begin
            miscompares++;
            $display("FAIL frame_cnt actual=%0d required=%0d", frame_cnt, fc_model);
        end
        vectors++;
        if ({pix_valid, busy} !== 2'b01) begin
            miscompares++;
            $display("FAIL post_eof {valid,busy} actual=%b required=01", {pix_valid, busy});
        end
    endtask

    // Counts the idle gap and checks what follows it.
    task automatic check_gap(input bit expect_run);
        int n;
        n = 0;
        while (busy === 1'b1 && pix_valid === 1'b0 && n <= GAP + 2) begin
            n++;
            @(negedge clk);
        end
        vectors++;
        if (n !== GAP) begin
            miscompares++;
            $display("FAIL gap_len actual=%0d required=%0d", n, GAP);
        end
        vectors++;
        if (expect_run) begin
            if (pix_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL gap_to_run valid actual=%b required=1", pix_valid);
            end
        end else begin
            if ({pix_valid, busy} !== 2'b00) begin
                miscompares++;
                $display("FAIL gap_to_idle {valid,busy} actual=%b required=00", {pix_valid, busy});
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        pix_ready = 1'b1;
        #1;
        vectors++;
        if ({pix_valid, pix_data, pix_col, pix_row, pix_eol, pix_eof, frame_cnt, busy} !== 29'd0) begin
            miscompares++;
            $display("FAIL reset_outputs actual=%08h required=0",
                     {pix_valid, pix_data, pix_col, pix_row, pix_eol, pix_eof, frame_cnt, busy});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        // en low: pix_ready alone must not start anything.
        vectors++;
        if ({pix_valid, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL idle_after_reset {valid,busy} actual=%b required=00", {pix_valid, busy});
        end
        $display("reset: outputs idle");
    endtask

    task automatic test_pattern0();
        @(posedge clk);
        #1;
        en      = 1'b1;
        pattern = 2'd0;
        @(negedge clk);
        vectors++;
        if (pix_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL start_latency_early valid actual=%b required=0", pix_valid);
        end
        @(negedge clk);
        vectors++;
        if (pix_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL start_latency valid actual=%b required=1", pix_valid);
        end
        run_frame(2'd0, 100, -1);
        end_frame();
    endtask

    task automatic test_stall_bars();
        pattern = 2'd2;
        check_gap(1'b1);
        run_frame(2'd2, 60, -1);
        end_frame();
    endtask

    task automatic test_pattern_change();
        pattern = 2'd1;
        check_gap(1'b1);
        chg_beat = 1000;
        chg_pat  = 2'd3;
        run_frame(2'd1, 80, -1);
        chg_beat = -1;
        end_frame();
        check_gap(1'b1);
        run_frame(2'd3, 100, -1);
        end_frame();
    endtask

    task automatic test_en_off();
        pattern = 2'd0;
        check_gap(1'b1);
        en_off_beat = 10 * COLS;
        run_frame(2'd0, 90, -1);
        en_off_beat = -1;
        end_frame();
        check_gap(1'b0);
        repeat (5) @(negedge clk);
        vectors++;
        if ({pix_valid, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL stays_idle {valid,busy} actual=%b required=00", {pix_valid, busy});
        end
    endtask

    task automatic test_reset_midframe();
        @(posedge clk);
        #1;
        en      = 1'b1;
        pattern = 2'd2;
        @(negedge clk);
        @(negedge clk);
        run_frame(2'd2, 100, 7 * COLS + 33);
        rst_n = 1'b0;
        #1;
        fc_model = 0;
        vectors++;
        if ({pix_valid, pix_data, pix_col, pix_row, pix_eol, pix_eof, frame_cnt, busy} !== 29'd0) begin
            miscompares++;
            $display("FAIL midframe_reset actual=%08h required=0",
                     {pix_valid, pix_data, pix_col, pix_row, pix_eol, pix_eof, frame_cnt, busy});
        end
        en = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({pix_valid, busy, frame_cnt} !== 10'd0) begin
            miscompares++;
            $display("FAIL after_midframe_reset {valid,busy,frame_cnt} actual=%03h required=0",
                     {pix_valid, busy, frame_cnt});
        end
        $display("midframe reset at row 7 col 33");
    endtask

    // Small instance: 16 beats + 1 gap cycle = 17 cycles per frame.
    task automatic test_frame_wrap();
        @(posedge clk);
        #1 s_en = 1'b1;
        repeat (16) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (s_frame_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL wrap_first_early actual=%0d required=0", s_frame_cnt);
        end
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (s_frame_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL wrap_first actual=%0d required=1", s_frame_cnt);
        end
        for (int n = 2; n <= 257; n++) begin
            repeat (17) @(posedge clk);
            @(negedge clk);
            vectors++;
            if (s_frame_cnt !== 8'(n % 256)) begin
                miscompares++;
                $display("FAIL wrap_frame n=%0d actual=%0d required=%0d", n, s_frame_cnt, n % 256);
            end
        end
        s_en = 1'b0;
        repeat (40) @(negedge clk);
        vectors++;
        if ({s_valid, s_data, s_col, s_row, s_eol, s_eof, s_busy} !== 14'd0) begin
            miscompares++;
            $display("FAIL small_idle actual=%04h required=0",
                     {s_valid, s_data, s_col, s_row, s_eol, s_eof, s_busy});
        end
        $display("frame counter wrap: 257 frames on small instance, frame_cnt=%0d", s_frame_cnt);
    endtask

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b0;
        en        = 1'b0;
        pattern   = 2'd0;
        pix_ready = 1'b0;
        s_en      = 1'b0;

        test_reset();
        test_pattern0();
        test_stall_bars();
        test_pattern_change();
        test_en_off();
        test_reset_midframe();
        test_frame_wrap();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/led_pixel_source.md
# led_pixel_source

Upstream stage of the LED panel driver: generates the pixel stream for a 1/32-scan dual-half RGB panel and hands it, one upper/lower pixel pair per beat, to the column shifter over a valid/ready handshake. Each beat carries its column index, its row address and end-of-row/end-of-frame markers, so the shifter can pulse SCLK per beat and LATCH/BLANK at row end. Content is a selectable built-in test pattern; the block replaces hard-coded `initial` data tables.

## Interface
- `COLS`, 64, pixels per row (power of two, ≥8)
- `ADDR_W`, 5, row-address width; rows per half = 2^ADDR_W
- `GAP_CYCLES`, 16, idle cycles between frames (≥1)

- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `en`  in  1  run enable; sampled only in IDLE and at frame end
- `pattern`  in  2  pattern select; sampled at frame start
- `pix_valid`  out  1  beat available
- `pix_ready`  in  1  shifter accepts beat
- `pix_data`  out  6  {b1,g1,r1,b0,g0,r0}; bit0 = upper-half red
- `pix_col`  out  log2(COLS)  column of current beat
- `pix_row`  out  ADDR_W  row address of current beat (drives A0..A4 downstream)
- `pix_eol`  out  1  high on last column of a row
- `pix_eof`  out  1  high on last column of last row
- `frame_cnt`  out  8  completed frames, wraps 255→0
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, RUN, GAP.
- IDLE: outputs idle; if `en`=1, latch `pattern`, col=0, row=0, go to RUN.
- RUN: `pix_valid`=1. Beat transfers on a cycle with `pix_valid & pix_ready`. On transfer: col+1; at col=COLS-1, col→0, row+1; at last row, row→0, `frame_cnt`+1, go to GAP.
- GAP: `pix_valid`=0 for exactly GAP_CYCLES cycles, then: `en`=1 → latch `pattern`, RUN; `en`=0 → IDLE.
- `en` deassert during RUN has no effect until frame completes (no partial frames).
- Stall: while `pix_valid & !pix_ready`, all `pix_*` outputs hold stable.
- Pixel for col c, row r; upper half row r, lower half row r+2^ADDR_W:
  - 0: alternating — r0=r1=(c even); other colours 0.
  - 1: checkerboard — upper rgb=3'b111 if (c^r)[0]=0, lower rgb=3'b111 if (c^r)[0]=1 (lower row has same parity since 2^ADDR_W is even, so halves are inverse).
  - 2: colour bars — bar = c[top 3 bits of column]; rgb0=rgb1={b,g,r}=bar.
  - 3: solid white — 6'b111111.
- `pix_eol` = (col==COLS-1); `pix_eof` = `pix_eol` & (row==2^ADDR_W-1); both combinational from registered col/row, therefore stable under stall.

## Timing
- Reset (async assert, sync release): state IDLE, `pix_valid`=0, `pix_data`=0, `pix_col`=0, `pix_row`=0, `pix_eol`=0, `pix_eof`=0, `frame_cnt`=0, `busy`=0.
- `en` high in IDLE at edge N → `pix_valid`=1 and first beat (col 0, row 0) visible after edge N+1.
- Registered pixel path, zero bubbles: with `pix_ready` held high, one beat per cycle; frame = COLS·2^ADDR_W cycles + GAP_CYCLES.
- `pix_data` registered; updates the cycle after a transfer, together with col/row.
- `frame_cnt` increments on the edge that transfers the `pix_eof` beat.
- `pix_ready` has no effect when `pix_valid`=0.
- `rst_n` low mid-frame: all outputs to reset values immediately; resume only via IDLE.

## Configuration
- `PATTERN_ANIM_EN`: defined → patterns use c' = (c + `frame_cnt`) mod COLS in place of c (pattern scrolls one column per frame); `pix_col` still reports true c. Undefined → c used directly, static image; `frame_cnt` still counts.

## Test plan
- Reset then `en`=1, `pattern`=0, `pix_ready`=1, COLS=64, ADDR_W=5 → 2048 consecutive beats, `pix_data` alternates 6'b001001/6'b000000 from col 0, `pix_eol` every 64th beat, single `pix_eof` on beat 2048, then 16 cycles `pix_valid`=0, `frame_cnt`=1.
- `pattern`=2, random `pix_ready` stalls → data/col/row constant across every stall; col 8 beat = 6'b001001, col 63 = 6'b111111; no beat lost or duplicated.
- Change `pattern` 1→3 mid-frame → current frame completes as checkerboard (row 0 col 0 = 6'b000111, col 1 = 6'b111000); next frame all 6'b111111.
- `en`=0 during row 10 → frame completes to `pix_eof`, GAP, then IDLE, `busy`=0.
- `rst_n` pulsed low at row 7 col 33 → outputs reset values in the same cycle, `frame_cnt`=0.
- With `PATTERN_ANIM_EN`, `pattern`=0: frame 0 col 0 lit, frame 1 col 0 dark/col 1 lit; after 256 frames `frame_cnt` wraps to 0.
